// File: rtl/mix_columns_seq.sv
`default_nettype none
// ============================================================================
// Module   : mix_columns_seq
// Brief    : Iterative AES MixColumns (COLS_PER_CYCLE columns per clock) with a
//            valid/ready handshake. Define MIX_COLUMNS_INV_EN to build the
//            InvMixColumns datapath; otherwise inv is ignored (forward only).
// Revision : 1.0 - initial release
// ============================================================================
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         inv,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    localparam logic [1:0] c_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] c_LAST = 2'(4 - COLS_PER_CYCLE);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
            $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                         r_state;
    logic [0:3][31:0]               r_work;
    logic [0:3][31:0]               r_out;
    logic [1:0]                     r_col_cnt;
    logic                           r_in_ready;
    logic                           r_out_valid;
    logic                           r_busy;
    logic [COLS_PER_CYCLE-1:0][31:0] w_res;
`ifdef MIX_COLUMNS_INV_EN
    logic                           r_mode;
`else
    logic                           w_unused_inv;
    assign w_unused_inv = inv;
`endif

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

`ifdef MIX_COLUMNS_INV_EN
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic mode);
`else
    function automatic logic [31:0] mix_col(input logic [31:0] col);
`endif
        logic [7:0]  a [4];
        logic [7:0]  b0, b1, b2, b3, v;
        logic [31:0] res;
        for (int i = 0; i < 4; i++) a[i] = col[31-8*i -: 8];
        res = '0;
        for (int r = 0; r < 4; r++) begin
            b0 = a[r];
            b1 = a[(r+1)%4];
            b2 = a[(r+2)%4];
            b3 = a[(r+3)%4];
            v  = xt(b0) ^ xt(b1) ^ b1 ^ b2 ^ b3;
`ifdef MIX_COLUMNS_INV_EN
            // 0E,0B,0D,09 built from the x2/x4/x8 chain of each byte
            if (mode)
                v = (xt(xt(xt(b0))) ^ xt(xt(b0)) ^ xt(b0))
                  ^ (xt(xt(xt(b1))) ^ xt(b1) ^ b1)
                  ^ (xt(xt(xt(b2))) ^ xt(xt(b2)) ^ b2)
                  ^ (xt(xt(xt(b3))) ^ b3);
`endif
            res[31-8*r -: 8] = v;
        end
        return res;
    endfunction

    generate
        for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
            logic [1:0] w_idx;
            assign w_idx = r_col_cnt + 2'(k);
`ifdef MIX_COLUMNS_INV_EN
            assign w_res[k] = mix_col(r_work[w_idx], r_mode);
`else
            assign w_res[k] = mix_col(r_work[w_idx]);
`endif
        end
    endgenerate

    // Handshake flags are state bits of their own so they never depend on inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_col_cnt   <= 2'd0;
            r_work      <= '0;
            r_out       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef MIX_COLUMNS_INV_EN
            r_mode      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_work     <= state_in;
                        r_col_cnt  <= 2'd0;
                        r_state    <= S_BUSY;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
`ifdef MIX_COLUMNS_INV_EN
                        r_mode     <= inv;
`endif
                    end
                end
                S_BUSY: begin
                    for (int k = 0; k < COLS_PER_CYCLE; k++)
                        r_out[r_col_cnt + 2'(k)] <= w_res[k];
                    r_col_cnt <= r_col_cnt + c_STEP;
                    if (r_col_cnt == c_LAST) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign state_out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_mix_columns_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mix_columns_seq
// Brief    : Self-checking bench driving mix_columns_seq at 1, 2 and 4 columns
//            per cycle in lockstep against a GF(2^8) matrix reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mix_columns_seq;

    logic               clk       = 1'b0;
    logic               reset     = 1'b1;
    logic               in_valid  = 1'b0;
    logic               inv       = 1'b0;
    logic               out_ready = 1'b0;
    logic [127:0]       state_in  = '0;
    logic [2:0]         in_ready;
    logic [2:0]         out_valid;
    logic [2:0]         busy;
    logic [2:0][127:0]  state_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
                .clk       (clk),
                .reset     (reset),
                .in_valid  (in_valid),
                .in_ready  (in_ready[g]),
                .inv       (inv),
                .state_in  (state_in),
                .out_valid (out_valid[g]),
                .out_ready (out_ready),
                .state_out (state_out[g]),
                .busy      (busy[g])
            );
        end
    endgenerate

    typedef struct {
        logic [127:0] din;
        logic         iv;
        logic [127:0] exp;
        int           hold;
    } vec_t;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [8:0] t;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            t = {a, 1'b0};
            if (t[8]) t = t ^ 9'h11b;
            a = t[7:0];
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic iv);
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [127:0] o = '0;
        logic         eff;
`ifdef MIX_COLUMNS_INV_EN
        eff = iv;
`else
        eff = 1'b0 & iv;
`endif
        if (eff) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(coef[(j - r + 4) % 4], s[127-32*c-8*j -: 8]);
                o[127-32*c-8*r -: 8] = acc;
            end
        return o;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One block into all three engines; garbage on the inputs while in flight
    task automatic run_block(input logic [127:0] d, input logic iv,
                             input logic [127:0] exp, input string nm, input int hold);
        for (int g = 0; g < 3; g++)
            chk($sformatf("%s/cpc%0d in_ready_pre", nm, 1 << g), 128'(in_ready[g]), 128'd1);
        state_in = d;
        inv      = iv;
        in_valid = 1'b1;
        tick();
        for (int n = 1; n <= 4 + hold; n++) begin
            state_in = {$urandom, $urandom, $urandom, $urandom};
            inv      = ~iv;
            tick();
            for (int g = 0; g < 3; g++) begin
                logic ov;
                ov = (n >= (4 >> g));
                chk($sformatf("%s/cpc%0d out_valid@%0d", nm, 1 << g, n), 128'(out_valid[g]), 128'(ov));
                chk($sformatf("%s/cpc%0d in_ready@%0d", nm, 1 << g, n), 128'(in_ready[g]), 128'd0);
                chk($sformatf("%s/cpc%0d busy@%0d", nm, 1 << g, n), 128'(busy[g]), 128'd1);
                if (ov)
                    chk($sformatf("%s/cpc%0d state_out@%0d", nm, 1 << g, n), state_out[g], exp);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("%s/cpc%0d out_valid_post", nm, 1 << g), 128'(out_valid[g]), 128'd0);
            chk($sformatf("%s/cpc%0d busy_post", nm, 1 << g), 128'(busy[g]), 128'd0);
            chk($sformatf("%s/cpc%0d in_ready_post", nm, 1 << g), 128'(in_ready[g]), 128'd1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [$];
        logic [127:0] d;
        logic         iv;
        int           hold;

        tbl.push_back('{128'h6353e08c0960e104cd70b751bacad0e7, 1'b0,
                        128'h5f72641557f5bc92f7be3b291db9f91a, 0});
        tbl.push_back('{128'h84e1dd691a41d76f792d389783fbac70, 1'b0,
                        128'h9f487f794f955f662afc86abd7f1ab29, 0});
        tbl.push_back('{128'h1fb5430ef0accf64aa370cde3d77792c, 1'b0,
                        128'hb7a53ecbbf9d75a0c40efc79b674cc11, 10});
`ifdef MIX_COLUMNS_INV_EN
        tbl.push_back('{128'h5f72641557f5bc92f7be3b291db9f91a, 1'b1,
                        128'h6353e08c0960e104cd70b751bacad0e7, 0});
        tbl.push_back('{128'h8e4da1bc8e4da1bc8e4da1bc8e4da1bc, 1'b1,
                        128'hdb135345db135345db135345db135345, 2});
`else
        tbl.push_back('{128'h6353e08c0960e104cd70b751bacad0e7, 1'b1,
                        128'h5f72641557f5bc92f7be3b291db9f91a, 0});
`endif

        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("reset/cpc%0d in_ready", 1 << g), 128'(in_ready[g]), 128'd0);
            chk($sformatf("reset/cpc%0d out_valid", 1 << g), 128'(out_valid[g]), 128'd0);
            chk($sformatf("reset/cpc%0d busy", 1 << g), 128'(busy[g]), 128'd0);
            chk($sformatf("reset/cpc%0d state_out", 1 << g), state_out[g], 128'd0);
        end
        reset = 1'b0;
        tick();

        for (int i = 0; i < tbl.size(); i++)
            run_block(tbl[i].din, tbl[i].iv, tbl[i].exp, $sformatf("vec%0d", i), tbl[i].hold);

        for (int i = 0; i < 20; i++) begin
            d    = {$urandom, $urandom, $urandom, $urandom};
            iv   = 1'($urandom_range(0, 1));
            hold = int'($urandom_range(0, 3));
            run_block(d, iv, model(d, iv), $sformatf("rnd%0d", i), hold);
        end

        // Abort in the second BUSY cycle (DONE already for the 4-column engine)
        state_in = 128'h84e1dd691a41d76f792d389783fbac70;
        inv      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("abort/cpc%0d out_valid", 1 << g), 128'(out_valid[g]), 128'd0);
            chk($sformatf("abort/cpc%0d state_out", 1 << g), state_out[g], 128'd0);
            chk($sformatf("abort/cpc%0d busy", 1 << g), 128'(busy[g]), 128'd0);
            chk($sformatf("abort/cpc%0d in_ready", 1 << g), 128'(in_ready[g]), 128'd0);
        end
        reset = 1'b0;
        tick();
        for (int g = 0; g < 3; g++)
            chk($sformatf("release/cpc%0d in_ready", 1 << g), 128'(in_ready[g]), 128'd1);
        run_block(128'h6353e08c0960e104cd70b751bacad0e7, 1'b0,
                  128'h5f72641557f5bc92f7be3b291db9f91a, "after_abort", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
